// File: rtl/serial_subtractor_nb.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock, LSB first.
// Start/busy/done handshake; diff and flags are registered and change only on completion.
module serial_subtractor_nb #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sres;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic             ai;
   logic             bi;
   logic             di;
   logic             brw_nx;
   logic             last;
   logic [WIDTH-1:0] res_nx;

   // Single full-subtractor cell fed from the operand LSBs.
   always_comb begin
      ai     = sa[0];
      bi     = sb[0];
      di     = ai ^ bi ^ brw;
      brw_nx = (~ai & bi) | (~(ai ^ bi) & brw);
      last   = (cnt == CW'(WIDTH - 1));
      res_nx = {di, sres[WIDTH-1:1]};
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         sres  <= '0;
         brw   <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  brw   <= bin;
                  sres  <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               sa   <= sa >> 1;
               sb   <= sb >> 1;
               brw  <= brw_nx;
               sres <= res_nx;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  // brw here is the borrow into the MSB, brw_nx the borrow out of it.
                  state <= DONE;
                  diff  <= res_nx;
                  bout  <= brw_nx;
                  zero  <= (res_nx == '0);
                  ovf   <= brw ^ brw_nx;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_nb.sv
// Bench for serial_subtractor_nb at WIDTH=4 and WIDTH=8: directed handshake cases
// plus a random sweep against an integer-arithmetic model of a - b - bin.
module tb_serial_subtractor_nb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic       bin_in = 1'b0;

   logic       busy4, done4, bout4, zero4, ovf4;
   logic [3:0] diff4;
   logic       busy8, done8, bout8, zero8, ovf8;
   logic [7:0] diff8;

   int checks = 0;
   int failures = 0;

   serial_subtractor_nb #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a_in[3:0]), .b(b_in[3:0]), .bin(bin_in),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4), .ovf(ovf4)
   );

   serial_subtractor_nb #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a_in), .b(b_in), .bin(bin_in),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8), .ovf(ovf8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   task automatic model(input int w, input int av, input int bv, input int bi,
                        output int d, output bit bo, output bit z, output bit ov);
      int r, sa, sb, sr, half;
      half = 1 << (w - 1);
      r    = av - bv - bi;
      d    = r & ((1 << w) - 1);
      bo   = (r < 0);
      z    = (d == 0);
      sa   = (av >= half) ? av - (1 << w) : av;
      sb   = (bv >= half) ? bv - (1 << w) : bv;
      sr   = sa - sb - bi;
      ov   = (sr < -half) || (sr > half - 1);
   endtask

   task automatic sample(input int w, output logic bz, output logic dn, output logic [7:0] dv,
                         output logic bo, output logic z, output logic ov);
      if (w == 4) begin
         bz = busy4; dn = done4; dv = {4'b0, diff4}; bo = bout4; z = zero4; ov = ovf4;
      end else begin
         bz = busy8; dn = done8; dv = diff8; bo = bout8; z = zero8; ov = ovf8;
      end
   endtask

   // Called at a negedge; start is sampled at the following posedge.
   task automatic launch(input int w, input int av, input int bv, input int bi);
      a_in   = 8'(av);
      b_in   = 8'(bv);
      bin_in = bi[0];
      if (w == 4) start4 = 1'b1; else start8 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   // Expects busy for exactly w cycles, then a done cycle carrying the model's result.
   task automatic expect_result(input int w, input int av, input int bv, input int bi);
      int d;
      bit ebo, ez, eov;
      logic bz, dn, bo, z, ov;
      logic [7:0] dv;
      bit lat_ok;
      lat_ok = 1'b1;
      model(w, av, bv, bi, d, ebo, ez, eov);
      for (int c = 1; c <= w; c++) begin
         @(negedge clk);
         sample(w, bz, dn, dv, bo, z, ov);
         if (!(bz === 1'b1 && dn === 1'b0)) lat_ok = 1'b0;
      end
      check("busy_window", 32'(lat_ok), 32'd1);
      @(negedge clk);
      sample(w, bz, dn, dv, bo, z, ov);
      check("done_cycle", {30'd0, bz, dn}, 32'd1);
      check("diff", 32'(dv), 32'(d));
      check("bout", 32'(bo), 32'(ebo));
      check("zero", 32'(z), 32'(ez));
      check("ovf", 32'(ov), 32'(eov));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic bz, dn, bo, z, ov;
      logic [7:0] dv;
      bit quiet;
      int da[5];
      int db[5];
      int dbin[5];
      da   = '{7, 3, 8, 5, 0};
      db   = '{3, 7, 1, 5, 0};
      dbin = '{0, 0, 0, 0, 1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      sample(4, bz, dn, dv, bo, z, ov);
      check("reset4", {26'd0, bz, dn, dv[3:0] == 4'd0 ? 1'b0 : 1'b1, bo, z, ov}, 32'd0);
      sample(8, bz, dn, dv, bo, z, ov);
      check("reset8", {18'd0, bz, dn, dv, bo, z, ov}, 32'd0);

      // Directed table, each launched from IDLE after one idle cycle.
      for (int i = 0; i < 5; i++) begin
         launch(4, da[i], db[i], dbin[i]);
         expect_result(4, da[i], db[i], dbin[i]);
         @(negedge clk);
      end

      // Start while busy is ignored; exactly one done follows.
      launch(4, 9, 2, 0);
      fork
         expect_result(4, 9, 2, 0);
         begin
            @(negedge clk);
            @(negedge clk);
            a_in = 8'd1; b_in = 8'd1; start4 = 1'b1;
            @(negedge clk);
            start4 = 1'b0;
         end
      join
      quiet = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         sample(4, bz, dn, dv, bo, z, ov);
         if (bz !== 1'b0 || dn !== 1'b0 || dv !== 8'd7 || bo !== 1'b0 || z !== 1'b0) quiet = 1'b0;
      end
      check("ignored_start_hold", 32'(quiet), 32'd1);

      // Start during the DONE cycle re-enters RUN immediately.
      launch(4, 5, 3, 0);
      expect_result(4, 5, 3, 0);
      launch(4, 6, 6, 0);
      expect_result(4, 6, 6, 0);
      launch(4, 13, 2, 0);
      expect_result(4, 13, 2, 0);

      // Reset in the second RUN cycle aborts the operation.
      @(negedge clk);
      launch(4, 12, 5, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      sample(4, bz, dn, dv, bo, z, ov);
      check("abort_state", {24'd0, bz, dn, dv[3:0] == 4'd0 ? 1'b0 : 1'b1, bo, z, ov, 2'b00}, 32'd0);
      quiet = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done4 !== 1'b0 || busy4 !== 1'b0) quiet = 1'b0;
      end
      check("abort_no_done", 32'(quiet), 32'd1);

      // Random sweeps, back-to-back starts through the DONE cycle.
      for (int i = 0; i < 1000; i++) begin
         int av, bv, bi;
         av = int'($urandom_range(0, 15));
         bv = int'($urandom_range(0, 15));
         bi = int'($urandom_range(0, 1));
         launch(4, av, bv, bi);
         expect_result(4, av, bv, bi);
      end
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         int av, bv, bi;
         av = int'($urandom_range(0, 255));
         bv = int'($urandom_range(0, 255));
         bi = int'($urandom_range(0, 1));
         launch(8, av, bv, bi);
         expect_result(8, av, bv, bi);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_nb.md
Name: serial_subtractor_nb

Overview:
- Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It is the subtract counterpart to the team's ripple adders.
- Intended for area-constrained datapaths where a multi-cycle result is acceptable.
- Uses a start/busy/done handshake and produces difference, borrow-out and status flags.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
clk    input   1      system clock; all logic on rising edge
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only when block is idle or in DONE cycle
a      input   WIDTH  minuend; captured on accepted start
b      input   WIDTH  subtrahend; captured on accepted start
bin    input   1      borrow-in; captured on accepted start
busy   output  1      high while a subtraction is in progress
done   output  1      one-cycle pulse; results valid and stable from this cycle
diff   output  WIDTH  a - b - bin modulo 2^WIDTH
bout   output  1      borrow-out: 1 when a < b + bin (unsigned)
zero   output  1      diff == 0
ovf    output  1      two's-complement overflow of the signed subtraction

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, on any edge with rst=1:
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0, zero = 0, ovf = 0.
  - Internal shift registers, borrow and bit counter cleared.
  - rst overrides start in the same cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture a, b, bin into internal registers; counter = 0; go RUN. start=0 -> stay.
  - RUN, each cycle:
    - bit i = counter, taken from the LSB of the shifted operands.
    - d_i = a_i ^ b_i ^ brw.
    - brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
    - d_i shifts into the MSB of the internal result register; operands shift right.
    - counter increments.
    - After the cycle processing bit WIDTH-1 -> go DONE.
  - DONE, lasts exactly one cycle:
    - done = 1.
    - start=1 -> accepted exactly as in IDLE, go RUN.
    - Otherwise go IDLE.
- Outputs diff, bout, zero, ovf:
  - Registered; updated only on the edge entering DONE.
  - Held unchanged until the next completion or reset; they never show partial results.
  - bout = final brw.
  - zero = (diff == 0).
  - ovf = borrow into the MSB XOR borrow out of the MSB. Equivalent: a[MSB] != b[MSB] and diff[MSB] != a[MSB], when bin=0.
- busy = 1 exactly while state == RUN. done = 1 exactly while state == DONE. busy and done are never both 1.
- Latency:
  - start accepted at edge k -> busy high in cycles k+1 .. k+WIDTH.
  - done high in cycle k+WIDTH+1 (WIDTH+1 cycles start-to-done).
  - Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1: ignored, no queuing. Operand inputs are don't-care outside an accepted start.
- Reset mid-RUN: operation aborted, no done pulse, outputs forced to reset values.
- Full wrap-around: diff is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=4, reset, then start with a=7, b=3, bin=0 -> busy for 4 cycles; done in the 5th cycle after start; diff=4, bout=0, zero=0, ovf=0.
- a=3, b=7, bin=0 -> diff=12 (0xC), bout=1, ovf=0. Then a=8, b=1, bin=0 -> diff=7, bout=0, ovf=1 (-8-1 overflow).
- a=5, b=5, bin=0 -> diff=0, zero=1, bout=0. Then a=0, b=0, bin=1 -> diff=15, bout=1, zero=0, ovf=0.
- start with a=9, b=2, then start with a=1, b=1 asserted 2 cycles later (busy) -> second start ignored; single done with diff=7. Outputs unchanged afterwards.
- start asserted during the done cycle with a=6, b=6 -> RUN re-entered immediately; next done exactly WIDTH+1 cycles later; diff=0, zero=1.
- rst=1 in the 2nd RUN cycle -> next cycle busy=0 and all outputs 0; no done pulse follows. Also a random 1000-vector sweep, run at WIDTH=4 and WIDTH=8, checked against (a - b - bin) mod 2^WIDTH plus the flag equations.
